// File: rtl/uart_rx_byte_if.sv
// Received-byte bus from the UART receiver to the key decoder.
interface uart_rx_byte_if;
   logic [7:0] data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   modport master (output data, rx_valid, frame_err, busy);
   modport slave  (input  data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, byte strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | half-bit wait, confirm start bit (high sample = glitch)
// S_DATA  | sample 8 data bits LSB-first, one bit period apart
// S_STOP  | sample stop bit; high -> byte strobe, low -> framing error
// S_BREAK | line held low after bad stop, wait for it to return high
module uart_rx_byte #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   uart_rx_byte_if.master rx_if
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bitn_q, bitn_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_meta_q, rx_s_q;

   // Bring the asynchronous line into the clk domain; idle level is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bitn_q      <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitn_q      <= bitn_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state and strobe logic; the baud counter is reloaded at every
   // terminal count so it never underflows.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitn_d      = bitn_q;
      shift_d     = shift_q;
      data_d      = data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = HALF_LD;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (!rx_s_q) begin
                  state_d = S_DATA;
                  cnt_d   = FULL_LD;
                  bitn_d  = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = FULL_LD;
               bitn_d  = bitn_q + 3'd1;
               if (bitn_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s_q) begin
                  data_d     = shift_q;
                  rx_valid_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_BREAK: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_if.data      = data_q;
   assign rx_if.rx_valid  = rx_valid_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at DIV = 16 (1.6 MHz clock, 100 kbit/s).
module tb_uart_rx_byte;

   localparam int BITC = 16;
   // Line drive at 1 ns after edge c0: two sync edges, detect on the third
   // (T0 = c0+3), stop sample at T0+8+9*16, strobe visible right after it.
   localparam int STROBE_LAT = 3 + 8 + 9 * 16;

   logic clk;
   logic reset;
   logic rx;
   int   cyc;
   int   n_checks;
   int   n_errors;

   int         v_tot, fe_tot, both_tot, busy_tot;
   logic [7:0] v_dat [0:31];
   int         v_cyc [0:31];
   int         fe_cyc[0:31];

   uart_rx_byte_if u_if ();

   uart_rx_byte #(
      .CLK_FREQ (1_600_000),
      .BAUD     (100_000)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .rx_if (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      v_tot = 0; fe_tot = 0; both_tot = 0; busy_tot = 0;
   end

   always @(negedge clk) begin
      if (u_if.rx_valid) begin
         v_dat[v_tot[4:0]] = u_if.data;
         v_cyc[v_tot[4:0]] = cyc;
         v_tot = v_tot + 1;
      end
      if (u_if.frame_err) begin
         fe_cyc[fe_tot[4:0]] = cyc;
         fe_tot = fe_tot + 1;
      end
      if (u_if.rx_valid && u_if.frame_err) both_tot = both_tot + 1;
      if (u_if.busy) busy_tot = busy_tot + 1;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "timeout");
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller is 1 ns after a clock edge; line is left at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int c_start);
      rx = 1'b0;
      c_start = cyc;
      idle(BITC);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(BITC);
      end
      rx = stop_bit;
      idle(BITC);
   endtask

   int c0, c1, v0, f0, b0;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rx    = 1'b1;
      reset = 1'b0;

      repeat (5) @(negedge clk);
      chk_eq("rst_data",      u_if.data,      8'h00);
      chk_eq("rst_rx_valid",  u_if.rx_valid,  1'b0);
      chk_eq("rst_frame_err", u_if.frame_err, 1'b0);
      chk_eq("rst_busy",      u_if.busy,      1'b0);

      @(posedge clk); #1;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk_eq("rel_busy", u_if.busy, 1'b0);
      chk_eq("rel_data", u_if.data, 8'h00);
      chk_eq("rel_strobes", v_tot + fe_tot, 0);
      idle(1);

      // Single byte 'w'.
      v0 = v_tot; f0 = fe_tot;
      send_frame(8'h77, 1'b1, c0);
      idle(20);
      chk_eq("w_count",   v_tot - v0, 1);
      chk_eq("w_data",    v_dat[v0[4:0]], 8'h77);
      chk_eq("w_latency", v_cyc[v0[4:0]] - c0, STROBE_LAT);
      chk_eq("w_fe",      fe_tot - f0, 0);
      chk_eq("w_busy",    u_if.busy, 1'b0);

      // Back-to-back CR then space.
      v0 = v_tot;
      send_frame(8'h0D, 1'b1, c0);
      send_frame(8'h20, 1'b1, c1);
      idle(20);
      chk_eq("b2b_count",   v_tot - v0, 2);
      chk_eq("b2b_data0",   v_dat[v0[4:0]], 8'h0D);
      chk_eq("b2b_data1",   v_dat[v0[4:0] + 5'd1], 8'h20);
      chk_eq("b2b_spacing", v_cyc[v0[4:0] + 5'd1] - v_cyc[v0[4:0]], 160);

      // 4-cycle glitch: start sample sees high, back to idle.
      v0 = v_tot; f0 = fe_tot; b0 = busy_tot;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(30);
      chk_eq("gl_strobes", (v_tot - v0) + (fe_tot - f0), 0);
      chk_eq("gl_busy_cycles", busy_tot - b0, 8);
      chk_eq("gl_busy_end", u_if.busy, 1'b0);

      // Bad stop bit then held-low line.
      v0 = v_tot; f0 = fe_tot;
      send_frame(8'h61, 1'b0, c0);
      idle(40);
      chk_eq("fe_busy_break", u_if.busy, 1'b1);
      rx = 1'b1;
      idle(30);
      chk_eq("fe_count",   fe_tot - f0, 1);
      chk_eq("fe_latency", fe_cyc[f0[4:0]] - c0, STROBE_LAT);
      chk_eq("fe_no_valid", v_tot - v0, 0);
      chk_eq("fe_data_kept", u_if.data, 8'h20);
      chk_eq("fe_busy_end", u_if.busy, 1'b0);
      v0 = v_tot; f0 = fe_tot;
      send_frame(8'h61, 1'b1, c0);
      idle(20);
      chk_eq("fe_recover_count", v_tot - v0, 1);
      chk_eq("fe_recover_data",  u_if.data, 8'h61);
      chk_eq("fe_recover_fe",    fe_tot - f0, 0);

      // Reset during data bit 3 of 'd'.
      v0 = v_tot; f0 = fe_tot;
      rx = 1'b0;
      idle(BITC);
      for (int i = 0; i < 3; i++) begin
         rx = c0[0] | 1'b0 ? 1'b0 : 1'b0;
         rx = (i == 2) ? 1'b1 : 1'b0;
         idle(BITC);
      end
      rx = 1'b0;
      idle(BITC / 2);
      reset = 1'b0;
      rx    = 1'b1;
      @(negedge clk);
      chk_eq("ra_busy", u_if.busy, 1'b0);
      chk_eq("ra_data", u_if.data, 8'h00);
      idle(10);
      reset = 1'b1;
      idle(30);
      chk_eq("ra_strobes", (v_tot - v0) + (fe_tot - f0), 0);
      chk_eq("ra_data_after", u_if.data, 8'h00);
      send_frame(8'h64, 1'b1, c0);
      idle(20);
      chk_eq("ra_next_count", v_tot - v0, 1);
      chk_eq("ra_next_data",  u_if.data, 8'h64);
      chk_eq("ra_next_latency", v_cyc[v0[4:0]] - c0, STROBE_LAT);

      chk_eq("never_both", both_tot, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
